// File: rtl/multigathering_serializer.sv
// Serializes a 16-line parallel snapshot onto serOut as a framed burst, driving PB/LB group/line selects per bit.
// Optional even-parity bit after the data bits: define MULTIGATHER_PARITY_EN.
module multigathering_serializer #(
  parameter int          GAP_CYCLES   = 2,
  parameter logic [15:0] MASK_DEFAULT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic [0:15] W,
  input  logic        mask_wr,
  input  logic [15:0] mask_in,
  output logic        serOut,
  output logic [3:0]  PB,
  output logic [1:0]  LB,
  output logic        busy,
  output logic        done
);

  // state   | meaning
  // S_IDLE  | waiting for start; mask writable
  // S_START | start bit on serOut
  // S_DATA  | snap[idx] on serOut, PB/LB select line idx
  // S_PAR   | even parity over sent bits (parity build only)
  // S_GAP   | forced idle spacing before next frame
`ifdef MULTIGATHER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_GAP} state_t;
`endif

  state_t      st, st_n;
  logic [15:0] mask, mask_n;
  logic [15:0] snap, snap_n;
  logic [3:0]  idx, idx_n;
  logic [3:0]  gcnt, gcnt_n;
  logic        ser_n, busy_n, done_n;
  logic [3:0]  pb_n;
  logic [1:0]  lb_n;
  logic        fin_data, fin_frame;
  logic [4:0]  first, nxt;

  // Lowest unmasked index >= lo; MSB flags whether one exists.
  function automatic logic [4:0] scan(input logic [15:0] m, input logic [4:0] lo);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i >= int'(lo) && !m[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  assign first = scan(mask, 5'd0);
  assign nxt   = scan(mask, {1'b0, idx} + 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_IDLE;
      mask   <= MASK_DEFAULT;
      snap   <= '0;
      idx    <= '0;
      gcnt   <= '0;
      serOut <= 1'b0;
      PB     <= '0;
      LB     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (!stall) begin
      st     <= st_n;
      mask   <= mask_n;
      snap   <= snap_n;
      idx    <= idx_n;
      gcnt   <= gcnt_n;
      serOut <= ser_n;
      PB     <= pb_n;
      LB     <= lb_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  always_comb begin
    st_n      = st;
    mask_n    = mask;
    snap_n    = snap;
    idx_n     = idx;
    gcnt_n    = gcnt;
    ser_n     = 1'b0;
    pb_n      = '0;
    lb_n      = '0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    fin_data  = 1'b0;
    fin_frame = 1'b0;

    case (st)
      S_IDLE: begin
        if (mask_wr) mask_n = mask_in;
        if (start) begin
          for (int i = 0; i < 16; i++) snap_n[i] = W[i];
          st_n   = S_START;
          ser_n  = 1'b1;
          busy_n = 1'b1;
        end
      end
      S_START: begin
        if (first[4]) begin
          st_n   = S_DATA;
          idx_n  = first[3:0];
          ser_n  = snap[first[3:0]];
          pb_n   = 4'b0001 << first[3:2];
          lb_n   = first[1:0];
          busy_n = 1'b1;
        end else begin
          fin_data = 1'b1;
        end
      end
      S_DATA: begin
        if (nxt[4]) begin
          idx_n  = nxt[3:0];
          ser_n  = snap[nxt[3:0]];
          pb_n   = 4'b0001 << nxt[3:2];
          lb_n   = nxt[1:0];
          busy_n = 1'b1;
        end else begin
          fin_data = 1'b1;
        end
      end
`ifdef MULTIGATHER_PARITY_EN
      S_PAR: fin_frame = 1'b1;
`endif
      S_GAP: begin
        if (gcnt == 4'd0) begin
          st_n = S_IDLE;
        end else begin
          gcnt_n = gcnt - 4'd1;
          busy_n = 1'b1;
        end
      end
      default: st_n = S_IDLE;
    endcase

`ifdef MULTIGATHER_PARITY_EN
    if (fin_data) begin
      st_n   = S_PAR;
      ser_n  = ^(snap & ~mask);
      busy_n = 1'b1;
    end
`else
    if (fin_data) fin_frame = 1'b1;
`endif

    // done rides on the first cycle after the last frame bit
    if (fin_frame) begin
      done_n = 1'b1;
      if (GAP_CYCLES == 0) begin
        st_n   = S_IDLE;
        busy_n = 1'b0;
      end else begin
        st_n   = S_GAP;
        busy_n = 1'b1;
        gcnt_n = 4'(GAP_CYCLES - 1);
      end
    end
  end

endmodule

// File: tb/tb_multigathering_serializer.sv
// Bench for multigathering_serializer: per-cycle comparison against a frame-trace model, plus literal pins.
module tb_multigathering_serializer;
  localparam int GAP = 2;
`ifdef MULTIGATHER_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, stall, mask_wr;
  logic [0:15] W;
  logic [15:0] mask_in;
  logic        serOut, busy, done;
  logic [3:0]  PB;
  logic [1:0]  LB;

  typedef logic [8:0] ent_t;  // {serOut, PB, LB, busy, done}
  typedef ent_t trace_t[$];

  trace_t      q;
  ent_t        seen[64];
  int          fcyc;
  bit          chk_en;
  int          n_cmp, n_bad;
  logic [15:0] mdl_mask;

  multigathering_serializer #(.GAP_CYCLES(GAP), .MASK_DEFAULT(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .W(W),
    .mask_wr(mask_wr), .mask_in(mask_in), .serOut(serOut), .PB(PB),
    .LB(LB), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  // Expected outputs for cycles 1.. of a frame, straight from the framing rules.
  function automatic trace_t build(input logic [0:15] w, input logic [15:0] m);
    trace_t t;
    logic   p;
    p = 1'b0;
    t.push_back({1'b1, 4'b0000, 2'b00, 1'b1, 1'b0});
    for (int i = 0; i < 16; i++) begin
      if (!m[i]) begin
        t.push_back({w[i], 4'(1 << (i / 4)), 2'(i % 4), 1'b1, 1'b0});
        p = p ^ w[i];
      end
    end
`ifdef MULTIGATHER_PARITY_EN
    t.push_back({p, 4'b0000, 2'b00, 1'b1, 1'b0});
`endif
    if (GAP == 0) t.push_back(9'b0_0000_00_0_1);
    else for (int g = 0; g < GAP; g++) t.push_back({7'b0, 1'b1, g == 0});
    return t;
  endfunction

  task automatic check(input string nm, input ent_t act, input ent_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [0:15] w, input bit do_mask, input logic [15:0] m,
                        input int stall_at, input int stall_n, input int trunc);
    trace_t t;
    W = w; start = 1'b1; mask_wr = do_mask; mask_in = m;
    if (do_mask) mdl_mask = m;
    t = build(w, mdl_mask);
    for (int k = 0; k < stall_n; k++) t.insert(stall_at - 1, t[stall_at - 1]);
    if (trunc > 0) while (t.size() > trunc) void'(t.pop_back());
    @(posedge clk);
    #1;
    start = 1'b0; mask_wr = 1'b0;
    q = t;
    fcyc = 1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin
      adv(1);
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d entries left want 0", q.size());
      q.delete();
    end
    adv(2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; mask_wr = 1'b0; mask_in = '0; W = '0;
    chk_en = 1'b0; n_cmp = 0; n_bad = 0; fcyc = 0; mdl_mask = 16'h0000;

    fork
      forever begin : cmp
        ent_t e, a;
        @(negedge clk);
        if (chk_en) begin
          e = (q.size() != 0) ? q.pop_front() : 9'b0;
          a = {serOut, PB, LB, busy, done};
          if (fcyc >= 0 && fcyc < 64) seen[fcyc] = a;
          n_cmp++;
          if (a !== e) begin
            n_bad++;
            $display("FAIL cyc%0d: got %b want %b", fcyc, a, e);
          end
          fcyc++;
        end
      end
    join_none

    adv(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset", {serOut, PB, LB, busy, done}, 9'b0);
    adv(2);

    // basic frame
    launch(16'hA001, 1'b0, 16'h0, 0, 0, 0);
    wait_idle();
    check("t1_c1", seen[1], {1'b1, 4'b0000, 2'd0, 1'b1, 1'b0});
    check("t1_c4", seen[4], {1'b1, 4'b0001, 2'd2, 1'b1, 1'b0});
    check("t1_c17", seen[17], {1'b1, 4'b1000, 2'd3, 1'b1, 1'b0});
    check("t1_done", seen[18 + PX], {7'b0, 1'b1, 1'b1});
    check("t1_gap2", seen[19 + PX], {7'b0, 1'b1, 1'b0});
    check("t1_idle", seen[20 + PX], 9'b0);

    // start ignored mid-frame and in gap; W toggles and mask_wr ignored mid-frame
    launch(16'h3C96, 1'b0, 16'h0, 0, 0, 0);
    adv(4); start = 1'b1;
    adv(1); start = 1'b0; W = 16'hC369; mask_wr = 1'b1; mask_in = 16'hFFFF;
    adv(1); mask_wr = 1'b0;
    adv(11); start = 1'b1;
    adv(1); start = 1'b0;
    wait_idle();
    check("t2_c2", seen[2], {1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
    check("t2_noframe", seen[20 + PX], 9'b0);

    // stall for 3 cycles while idx=5
    launch(16'h5A3C, 1'b0, 16'h0, 7, 3, 0);
    adv(6); stall = 1'b1;
    adv(3); stall = 1'b0;
    wait_idle();
    check("t3_hold", seen[10], {1'b0, 4'b0010, 2'd1, 1'b1, 1'b0});
    check("t3_idx6", seen[11], {1'b1, 4'b0010, 2'd2, 1'b1, 1'b0});
    check("t3_done", seen[21 + PX], {7'b0, 1'b1, 1'b1});

    // mask loaded together with start
    launch(16'hFFFF, 1'b1, 16'hFF00, 0, 0, 0);
    wait_idle();
    check("t4_c9", seen[9], {1'b1, 4'b0010, 2'd3, 1'b1, 1'b0});
`ifdef MULTIGATHER_PARITY_EN
    check("t4_par", seen[10], {1'b0, 4'b0000, 2'd0, 1'b1, 1'b0});
`endif
    check("t4_done", seen[10 + PX], {7'b0, 1'b1, 1'b1});

    // everything masked
    launch(16'h1234, 1'b1, 16'hFFFF, 0, 0, 0);
    wait_idle();
    check("t5_done", seen[2 + PX], {7'b0, 1'b1, 1'b1});
    mask_wr = 1'b1; mask_in = 16'h0000;
    adv(1);
    mask_wr = 1'b0; mdl_mask = 16'h0000;
    adv(1);

    // reset mid-frame
    launch(16'hFFFF, 1'b0, 16'h0, 0, 0, 9);
    adv(8); rst = 1'b1;
    adv(1); rst = 1'b0; mdl_mask = 16'h0000;
    wait_idle();
    check("t6_c9", seen[9], {1'b1, 4'b0010, 2'd3, 1'b1, 1'b0});
    check("t6_abort", seen[10], 9'b0);
    check("t6_nodone", seen[11], 9'b0);

    // fresh frame after reset
    launch(16'h8001, 1'b0, 16'h0, 0, 0, 0);
    wait_idle();
    check("t7_c17", seen[17], {1'b1, 4'b1000, 2'd3, 1'b1, 1'b0});
    check("t7_done", seen[18 + PX], {7'b0, 1'b1, 1'b1});

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multigathering_serializer.md
Name: multigathering_serializer

Overview:
- Transmit-side counterpart of the serial multibroadcasting demux.
- Snapshots 16 parallel lines W[0:15] and shifts them onto a single serial line, serOut, as one framed burst.
- While each bit is on serOut, drives the matching group select (PB, one-hot) and line select (LB, binary). A downstream multibroadcasting demux fed from serOut/PB/LB therefore reproduces W on its outputs.
- Sits between the parallel line sources and the shared serial link.

Parameters:
- GAP_CYCLES, 2, idle cycles forced after each frame before a new start is accepted (0..15).
- MASK_DEFAULT, 16'h0000, reset value of the line skip mask; a 1 suppresses that line (bit i = line W[i]).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  frame request; sampled only in IDLE
- stall  input  1  while high, freezes the FSM, counters and all outputs
- W  input  [0:15]  parallel lines; captured on the accepting edge
- mask_wr  input  1  load mask register from mask_in (accepted only in IDLE)
- mask_in  input  [15:0]  new skip mask
- serOut  output  1  serial data
- PB  output  [3:0]  one-hot group select = onehot(idx[3:2]), PB[g] for group g
- LB  output  [1:0]  line select = idx[1:0]
- busy  output  1  frame or gap in progress
- done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset, at the rising edge with rst=1:
  - state=IDLE; serOut=0, PB=0, LB=0, busy=0, done=0.
  - mask=MASK_DEFAULT; snapshot=0; idx=0; gap counter=0.
  - Reset dominates stall and start. Reset mid-frame aborts the frame with no done pulse.
- All outputs are registered.
- States are IDLE, START, DATA, PAR (only when parity is compiled in), GAP.
- IDLE:
  - serOut=0, PB=0, LB=0.
  - With start=1 and stall=0, the edge captures W into snap and goes to START.
  - mask_wr=1 in IDLE loads the mask. If start and mask_wr are both high, the mask loads first and applies to this frame.
  - mask_wr outside IDLE is ignored.
- START (1 cycle):
  - serOut=1 (start bit), PB=0, LB=0, busy=1.
  - Next state is DATA with idx = first unmasked index. If all 16 lines are masked, next state is PAR/GAP and no data bits are sent.
- DATA:
  - serOut=snap[idx], PB=onehot(idx[3:2]), LB=idx[1:0].
  - Each cycle, idx advances to the next unmasked index in ascending order.
  - After the highest unmasked index, go to PAR if compiled in, otherwise GAP.
  - Bit count = popcount(~mask).
- GAP:
  - serOut=0, PB=0, LB=0, busy=1.
  - Lasts GAP_CYCLES cycles, then IDLE.
  - With GAP_CYCLES=0, go straight to IDLE.
- done:
  - High for exactly one cycle, the first cycle after the last frame bit (first GAP cycle, or the IDLE cycle when GAP_CYCLES=0).
  - busy=0 in that IDLE cycle.
- Latency, start accepted at edge 0 with no mask and no parity:
  - Start bit in cycle 1.
  - W[i] in cycle 2+i.
  - done in cycle 18.
  - busy high for cycles 1..17+GAP_CYCLES.
- start while busy=1 is ignored and not queued. W changes after capture do not affect the frame in flight.
- stall=1 holds every register, including done. A pending done pulse therefore stretches while stalled.

Optional Feature:
- Macro: MULTIGATHER_PARITY_EN.
- Defined:
  - A PAR state follows DATA (or START when all lines are masked).
  - serOut = even parity over the transmitted (unmasked) data bits; PB=0, LB=0.
  - Adds 1 cycle; done moves to cycle 19 in the unmasked case.
- Undefined: PAR state and its logic are absent; DATA goes directly to GAP.

Test Plan:
- Reset, then start=1 with W=16'b1010_0000_0000_0001, mask=0, GAP_CYCLES=2 -> serOut:
  - cycle 1 = 1 (start bit);
  - cycles 2..17 = 1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,1;
  - PB=0001 during cycles 2–5 and 1000 during cycles 14–17; LB cycles 0,1,2,3;
  - done high in cycle 18 only; busy falls after cycle 19.
- mask_in=16'hFF00 (W[8..15] skipped) loaded with start, W=16'hFFFF -> 8 data bits, all 1, with PB=0001 then 0010. done in cycle 10; with parity, serOut=0 in cycle 10 and done in cycle 11.
- start pulsed at cycles 5 and 18 of an active frame -> both ignored; no second frame; snap unchanged when W toggles mid-frame.
- stall=1 for 3 cycles while idx=5 -> serOut, PB=0010 and LB=01 hold; frame completes 3 cycles late, bit order intact.
- rst=1 at cycle 9 of a frame -> next cycle serOut=0, PB=0, busy=0; no done pulse. A fresh start then produces a full frame.
- mask=16'hFFFF -> START then GAP; done in cycle 2; no PB activity.
